// File: rtl/wrr4_req_ctrl.sv
// wrr4_req_ctrl: doorbell-fed pending counters driving a 4-way WRR arbiter and streaming fixed-length TX bursts.
// Optional per-queue grant statistics are built when WRR4_REQ_STATS_EN is defined.
module wrr4_req_ctrl #(
  parameter int CNT_W = 4,
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        db_val,
  input  logic [1:0]  db_qid,
  output logic        db_drop,
  output logic        req_val,
  output logic        req0,
  output logic        req1,
  output logic        req2,
  output logic        req3,
  input  logic        gnt0,
  input  logic        gnt1,
  input  logic        gnt2,
  input  logic        gnt3,
  output logic        gnt_busy,
  output logic        gnt_err,
  output logic        tx_val,
  output logic [1:0]  tx_qid,
  output logic        tx_last,
  input  logic        tx_rdy,
  input  logic [1:0]  stat_sel,
  output logic [15:0] stat_cnt
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_pend [4];
  logic [4:0]       r_beat;
  logic [1:0]       r_qid;
  logic             r_err, r_drop;
  logic [3:0]       w_gnt, w_req, w_inc, w_dec;
  logic [1:0]       w_idx;
  logic             w_legal, w_last;
  assign w_gnt   = {gnt3, gnt2, gnt1, gnt0};
  assign w_idx   = w_gnt[3] ? 2'd3 : w_gnt[2] ? 2'd2 : w_gnt[1] ? 2'd1 : 2'd0;
  assign w_legal = (r_state == IDLE) && (w_gnt != 4'd0) && ((w_gnt & (w_gnt - 4'd1)) == 4'd0) && w_req[w_idx];
  assign w_last  = (r_beat == 5'(BEATS - 1));
  always_comb begin
    w_req = '0;
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < 4; i++) begin
      w_req[i] = (r_pend[i] != '0);
      w_inc[i] = db_val && (db_qid == 2'(i));
      w_dec[i] = w_legal && (w_idx == 2'(i));
    end
  end
  // Same-cycle increment and decrement cancel; a saturated counter drops the doorbell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_pend[i] <= '0;
      r_drop <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_inc[i] && !w_dec[i] && r_pend[i] != '1) r_pend[i] <= r_pend[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_pend[i] <= r_pend[i] - 1'b1;
      r_drop <= db_val && !w_dec[db_qid] && (r_pend[db_qid] == '1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_qid   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_legal) begin
        r_state <= XFER;
        r_qid   <= w_idx;
        r_beat  <= '0;
      end else if (w_gnt != 4'd0) r_err <= 1'b1;
    end else if (tx_rdy) begin
      r_beat <= r_beat + 5'd1;
      if (w_last) r_state <= IDLE;
    end
  end
  assign {req3, req2, req1, req0} = w_req;
  assign req_val  = |w_req;
  assign gnt_busy = (r_state == XFER);
  assign tx_val   = (r_state == XFER);
  assign tx_last  = (r_state == XFER) && w_last;
  assign tx_qid   = r_qid;
  assign gnt_err  = r_err;
  assign db_drop  = r_drop;
`ifdef WRR4_REQ_STATS_EN
  logic [15:0] r_stat [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    else if (w_legal) r_stat[w_idx] <= r_stat[w_idx] + 16'd1;
  end
  assign stat_cnt = r_stat[stat_sel];
`else
  logic w_unused_stat;
  assign w_unused_stat = ^stat_sel;
  assign stat_cnt = '0;
`endif
endmodule
